debounce_bank: RTL
==================

# debounce_bank

Parametrised multi-channel push-button conditioner for the correlator front panel. It replaces per-button debouncers with one bank of N independent channels. Each channel has:
- an input synchroniser;
- a saturating up/down integrator with hysteresis thresholds;
- a per-channel momentary/toggle mode;
- single-cycle press and release pulses;
- optional long-press detection.

Outputs feed the control FSM directly.

## Interface
- N, 4: number of channels
- CNT_W, 18: integrator width
- CNT_MAX, 25000: integrator saturation value
- TH_HI, 24000: level-set threshold
- TH_LO, 10000: level-clear threshold; legal only if 0 < TH_LO < TH_HI <= CNT_MAX < 2^CNT_W
- LONG_W, 26: long-press counter width
- LONG_CYC, 50000000: cycles of stable level before the long-press pulse
- clk  in  1  system clock
- rst  in  1  reset, asynchronous assert, active-high; all state clears
- raw  in  N  unsynchronised button inputs, 1 = pressed
- mode  in  N  per channel: 0 = momentary, 1 = toggle
- level  out  N  debounced level
- press  out  N  mode=0: equals level; mode=1: toggle state
- rise_p  out  N  one-cycle pulse on debounced press
- fall_p  out  N  one-cycle pulse on debounced release
- long_p  out  N  one-cycle pulse on long press; tied 0 when the feature is compiled out

## Operation
- raw passes through a 2-FF synchroniser, giving s.
- Integrator cnt, per clock edge:
  - s=1 and cnt<CNT_MAX: cnt+1;
  - s=0 and cnt>0: cnt−1;
  - otherwise hold (saturates at both ends).
- Level update uses cnt_next, the integrator value being written on that edge:
  - cnt_next >= TH_HI: level ← 1;
  - cnt_next <= TH_LO: level ← 0;
  - otherwise hold.
- rise_p ← level_next & ~level; fall_p ← ~level_next & level. Both are registered and change on the same edge as level.
- Toggle register tog:
  - mode=1: flips on every edge where rise_p is written 1;
  - mode=0: tog ← level_next every cycle, so switching to toggle mode starts from the current level.
- Long-press counter lc, saturating at LONG_CYC:
  - counts while level=1;
  - clears on level=0.
  - long_p pulses exactly once, on the edge where lc becomes LONG_CYC.
  - Release and re-press re-arm it.
- Channels are fully independent; no shared state.

## Timing
- Reset values: cnt=0, sync FFs=0, level=0, tog=0, lc=0. So level, press, rise_p, fall_p and long_p are all 0.
- Reset mid-press: all outputs drop asynchronously, with no fall_p. After release of rst a still-held button needs the full TH_HI+2 edges to reassert.
- Press latency from cnt=0 with raw held at 1: level and rise_p assert on edge TH_HI+2, counting from the first edge that samples raw=1.
- Release latency from cnt=CNT_MAX: level clears on edge (CNT_MAX−TH_LO)+2.
- Bounce faster than the thresholds never changes level. A single-cycle glitch moves cnt by at most 1.
- A mode change takes effect on the next edge. A mode change on the same edge as rise_p uses the new mode value.
- long_p follows rise_p by LONG_CYC−1 edges.

## Configuration
- DEBOUNCE_LONGPRESS_EN defined: the lc counters and long_p logic are built.
- Undefined: no lc registers are instantiated and long_p is constant 0. All other behaviour is identical.

## Structure
- Package debounce_pkg holds:
  - default constants (DB_CNT_W, DB_CNT_MAX, DB_TH_HI, DB_TH_LO, DB_LONG_W, DB_LONG_CYC);
  - a parameter-legality check function used in an initial assertion.
- Sub-module debounce_channel contains the synchroniser, integrator, level, toggle and long-press logic for one channel.
- debounce_bank is a generate loop of N debounce_channel instances.

## Test plan
Bench parameters: N=4, CNT_MAX=20, TH_HI=16, TH_LO=4, LONG_CYC=50, DEBOUNCE_LONGPRESS_EN defined.

- **Clean press:** raw[0]=1 from reset → level[0] and rise_p[0] go 1 on edge 18; rise_p[0] lasts exactly 1 cycle; channels 1–3 stay 0.
- **Bounce:** raw[1] alternates 1/0 every cycle for 200 cycles → level[1], rise_p[1] and fall_p[1] stay 0.
- **Release:** channel 0 saturated at 20, then raw[0]=0 → fall_p[0] and level[0]=0 on edge 18 after the release.
- **Toggle:** mode[2]=1, two full press/release cycles → press[2] goes 0→1 on the first rise_p and 1→0 on the second. Then mode[2]=0 while released → press[2]=0 on the next edge.
- **Long press:** raw[3] held for 120 cycles → exactly one long_p[3] pulse, 49 edges after rise_p[3]. Release and re-press for 120 cycles → a second pulse.
- **Reset mid-operation:** assert rst while level[0]=1 → all outputs 0 immediately, no fall_p. Release rst with raw[0]=1 → rise_p[0] on edge 18 after reset release.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared defaults and parameter-legality check for the debounce bank.
package debounce_pkg;

    localparam int unsigned DB_CNT_W    = 18;
    localparam int unsigned DB_CNT_MAX  = 25000;
    localparam int unsigned DB_TH_HI    = 24000;
    localparam int unsigned DB_TH_LO    = 10000;
    localparam int unsigned DB_LONG_W   = 26;
    localparam int unsigned DB_LONG_CYC = 50000000;

    // Thresholds must nest inside the integrator range, and both counters must fit their widths.
    function automatic bit db_params_ok(
        input int unsigned cnt_w,
        input int unsigned cnt_max,
        input int unsigned th_hi,
        input int unsigned th_lo,
        input int unsigned long_w,
        input int unsigned long_cyc
    );
        longint unsigned cnt_lim;
        longint unsigned long_lim;
        cnt_lim  = 64'd1 << cnt_w;
        long_lim = 64'd1 << long_w;
        return (cnt_w >= 1) && (cnt_w <= 32) && (long_w >= 1) && (long_w <= 32) &&
               (th_lo > 0) && (th_lo < th_hi) && (th_hi <= cnt_max) &&
               (64'(cnt_max) < cnt_lim) &&
               (long_cyc > 0) && (64'(long_cyc) < long_lim);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: synchroniser, hysteresis integrator, edge pulses, toggle, long press.
// Long-press logic is built only when DEBOUNCE_LONGPRESS_EN is defined.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned CNT_W    = DB_CNT_W,
    parameter int unsigned CNT_MAX  = DB_CNT_MAX,
    parameter int unsigned TH_HI    = DB_TH_HI,
    parameter int unsigned TH_LO    = DB_TH_LO,
    parameter int unsigned LONG_W   = DB_LONG_W,
    parameter int unsigned LONG_CYC = DB_LONG_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic mode,
    output logic level,
    output logic press,
    output logic rise_p,
    output logic fall_p,
    output logic long_p
);

    localparam logic [CNT_W-1:0] CNT_MAX_V = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] TH_HI_V   = CNT_W'(TH_HI);
    localparam logic [CNT_W-1:0] TH_LO_V   = CNT_W'(TH_LO);

    initial begin
        assert (db_params_ok(CNT_W, CNT_MAX, TH_HI, TH_LO, LONG_W, LONG_CYC))
        else $error("debounce_channel: illegal parameter set");
    end

    logic [1:0]       sync_q;
    logic             s;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             level_next;
    logic             rise_next;
    logic             fall_next;
    logic             tog;
    logic             tog_next;

    assign s     = sync_q[1];
    assign press = tog;

    // Level decisions look at the integrator value being written this edge.
    always_comb begin
        cnt_next = cnt;
        if (s && (cnt < CNT_MAX_V)) begin
            cnt_next = cnt + CNT_W'(1);
        end else if (!s && (cnt != '0)) begin
            cnt_next = cnt - CNT_W'(1);
        end
        level_next = level;
        if (cnt_next >= TH_HI_V) begin
            level_next = 1'b1;
        end else if (cnt_next <= TH_LO_V) begin
            level_next = 1'b0;
        end
        rise_next = level_next & ~level;
        fall_next = ~level_next & level;
        // In momentary mode tog shadows level so a switch to toggle starts from the current level.
        tog_next  = mode ? (tog ^ rise_next) : level_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
            cnt    <= '0;
            level  <= 1'b0;
            rise_p <= 1'b0;
            fall_p <= 1'b0;
            tog    <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            cnt    <= cnt_next;
            level  <= level_next;
            rise_p <= rise_next;
            fall_p <= fall_next;
            tog    <= tog_next;
        end
    end

`ifdef DEBOUNCE_LONGPRESS_EN
    localparam logic [LONG_W-1:0] LONG_V = LONG_W'(LONG_CYC);

    logic [LONG_W-1:0] lc;
    logic [LONG_W-1:0] lc_next;

    // Counting from level_next puts the pulse LONG_CYC-1 edges after rise_p.
    always_comb begin
        lc_next = '0;
        if (level_next) begin
            lc_next = (lc < LONG_V) ? (lc + LONG_W'(1)) : lc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lc     <= '0;
            long_p <= 1'b0;
        end else begin
            lc     <= lc_next;
            long_p <= (lc != LONG_V) && (lc_next == LONG_V);
        end
    end
`else
    assign long_p = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// Bank of N independent push-button debounce channels.
// Optional long-press detection: define DEBOUNCE_LONGPRESS_EN.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned CNT_W    = DB_CNT_W,
    parameter int unsigned CNT_MAX  = DB_CNT_MAX,
    parameter int unsigned TH_HI    = DB_TH_HI,
    parameter int unsigned TH_LO    = DB_TH_LO,
    parameter int unsigned LONG_W   = DB_LONG_W,
    parameter int unsigned LONG_CYC = DB_LONG_CYC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] raw,
    input  logic [N-1:0] mode,
    output logic [N-1:0] level,
    output logic [N-1:0] press,
    output logic [N-1:0] rise_p,
    output logic [N-1:0] fall_p,
    output logic [N-1:0] long_p
);

    for (genvar i = 0; i < int'(N); i++) begin : g_ch
        debounce_channel #(
            .CNT_W    (CNT_W),
            .CNT_MAX  (CNT_MAX),
            .TH_HI    (TH_HI),
            .TH_LO    (TH_LO),
            .LONG_W   (LONG_W),
            .LONG_CYC (LONG_CYC)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .raw    (raw[i]),
            .mode   (mode[i]),
            .level  (level[i]),
            .press  (press[i]),
            .rise_p (rise_p[i]),
            .fall_p (fall_p[i]),
            .long_p (long_p[i])
        );
    end

endmodule
